// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - baud rate constants, preset select encoding and divisor helper
package baud_pkg;

  localparam int unsigned BAUD_RATE_115200 = 115_200;
  localparam int unsigned BAUD_RATE_38400  = 38_400;
  localparam int unsigned BAUD_RATE_19200  = 19_200;
  localparam int unsigned BAUD_RATE_9600   = 9_600;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic [1:0] {
    BAUD_115200 = 2'b00,
    BAUD_38400  = 2'b01,
    BAUD_19200  = 2'b10,
    BAUD_9600   = 2'b11
  } baud_sel_e;

  // Fixed-point clk cycles per oversample tick, rounded to nearest: the
  // integer part sits above bit frac_w, the fraction below it.
  function automatic longint unsigned baud_div(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned os,
    input int unsigned     frac_w = 0
  );
    longint unsigned den;
    den = baud * os;
    return ((clk_freq << frac_w) + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/baud_bit_divider.sv
// rtl/baud_bit_divider.sv - counts oversample wraps into bit_tick and a bit-rate out_clk
module baud_bit_divider
  import baud_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic os_wrap,
  output logic bit_tick,
  output logic out_clk
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  logic [OS_W-1:0] os_cnt;

  // os_wrap is the same-edge wrap strobe, so bit_tick lines up with os_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      os_cnt   <= '0;
      bit_tick <= 1'b0;
      out_clk  <= 1'b0;
    end else if (os_wrap) begin
      bit_tick <= (os_cnt == OS_LAST);
      os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      if ((os_cnt == OS_HALF) || (os_cnt == OS_LAST)) begin
        out_clk <= ~out_clk;
      end
    end else begin
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - UART oversample/bit tick generator with glitch-free divisor reload
// Optional fractional divisor when BAUD_FRAC_EN is defined.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
`ifdef BAUD_FRAC_EN
  ,
  parameter int unsigned FRAC_W     = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic             use_custom,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] div_frac_in,
`endif
  output logic             os_tick,
  output logic             bit_tick,
  output logic             out_clk
);

`ifdef BAUD_FRAC_EN
  localparam int unsigned FW = FRAC_W;
`else
  localparam int unsigned FW = 0;
`endif

  localparam longint unsigned FX_0 = baud_div(CLK_FREQ, BAUD_RATE_115200, OVERSAMPLE, FW);
  localparam longint unsigned FX_1 = baud_div(CLK_FREQ, BAUD_RATE_38400, OVERSAMPLE, FW);
  localparam longint unsigned FX_2 = baud_div(CLK_FREQ, BAUD_RATE_19200, OVERSAMPLE, FW);
  localparam longint unsigned FX_3 = baud_div(CLK_FREQ, BAUD_RATE_9600, OVERSAMPLE, FW);

  localparam logic [DIV_W-1:0] PRE_DIV_0 = DIV_W'(FX_0 >> FW);
  localparam logic [DIV_W-1:0] PRE_DIV_1 = DIV_W'(FX_1 >> FW);
  localparam logic [DIV_W-1:0] PRE_DIV_2 = DIV_W'(FX_2 >> FW);
  localparam logic [DIV_W-1:0] PRE_DIV_3 = DIV_W'(FX_3 >> FW);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] custom_div;
  logic [DIV_W-1:0] cust_src;
  logic [DIV_W-1:0] preset_div;
  logic [DIV_W-1:0] raw_div;
  logic [DIV_W-1:0] eff_div;
  logic [DIV_W-1:0] last_cnt;
  logic             wrap;
  logic             os_wrap;

  // A load on the wrap edge must already feed that wrap's reload, and reset
  // must see the cleared custom register.
  always_comb begin
    cust_src = custom_div;
    if (reset) begin
      cust_src = '0;
    end else if (div_load) begin
      cust_src = div_in;
    end

    preset_div = PRE_DIV_0;
    case (baud_sel_e'(sel))
      BAUD_115200: preset_div = PRE_DIV_0;
      BAUD_38400:  preset_div = PRE_DIV_1;
      BAUD_19200:  preset_div = PRE_DIV_2;
      BAUD_9600:   preset_div = PRE_DIV_3;
      default:     preset_div = PRE_DIV_0;
    endcase

    raw_div = use_custom ? cust_src : preset_div;
    eff_div = (raw_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : raw_div;
  end

`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] PRE_FRAC_0 = FRAC_W'(FX_0);
  localparam logic [FRAC_W-1:0] PRE_FRAC_1 = FRAC_W'(FX_1);
  localparam logic [FRAC_W-1:0] PRE_FRAC_2 = FRAC_W'(FX_2);
  localparam logic [FRAC_W-1:0] PRE_FRAC_3 = FRAC_W'(FX_3);

  logic [FRAC_W-1:0] custom_frac;
  logic [FRAC_W-1:0] cust_frac_src;
  logic [FRAC_W-1:0] preset_frac;
  logic [FRAC_W-1:0] eff_frac;
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W:0]   acc_sum;
  logic              stretch;

  always_comb begin
    cust_frac_src = custom_frac;
    if (reset) begin
      cust_frac_src = '0;
    end else if (div_load) begin
      cust_frac_src = div_frac_in;
    end

    preset_frac = PRE_FRAC_0;
    case (baud_sel_e'(sel))
      BAUD_115200: preset_frac = PRE_FRAC_0;
      BAUD_38400:  preset_frac = PRE_FRAC_1;
      BAUD_19200:  preset_frac = PRE_FRAC_2;
      BAUD_9600:   preset_frac = PRE_FRAC_3;
      default:     preset_frac = PRE_FRAC_0;
    endcase

    eff_frac = use_custom ? cust_frac_src : preset_frac;
    acc_sum  = {1'b0, frac_acc} + {1'b0, eff_frac};
  end

  // A carry out of the accumulator stretches the following period by one clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      custom_frac <= '0;
      frac_acc    <= '0;
      stretch     <= 1'b0;
    end else begin
      if (div_load) begin
        custom_frac <= div_frac_in;
      end
      if (os_wrap) begin
        frac_acc <= acc_sum[FRAC_W-1:0];
        stretch  <= acc_sum[FRAC_W];
      end
    end
  end

  assign last_cnt = div_q - DIV_W'(1) + DIV_W'(stretch);
`else
  assign last_cnt = div_q - DIV_W'(1);
`endif

  assign wrap    = (cnt == last_cnt);
  assign os_wrap = en & wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      os_tick    <= 1'b0;
      div_q      <= eff_div;
      custom_div <= '0;
    end else begin
      if (div_load) begin
        custom_div <= div_in;
      end
      if (en) begin
        if (wrap) begin
          cnt     <= '0;
          os_tick <= 1'b1;
          div_q   <= eff_div;
        end else begin
          cnt     <= cnt + DIV_W'(1);
          os_tick <= 1'b0;
        end
      end else begin
        os_tick <= 1'b0;
      end
    end
  end

  baud_bit_divider #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_divider (
    .clk     (clk),
    .reset   (reset),
    .os_wrap (os_wrap),
    .bit_tick(bit_tick),
    .out_clk (out_clk)
  );

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - scoreboard bench for baud_tick_gen at default parameters
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  sel;
  logic        use_custom;
  logic        div_load;
  logic [15:0] div_in;
`ifdef BAUD_FRAC_EN
  logic [3:0]  div_frac_in;
`endif
  logic        os_tick;
  logic        bit_tick;
  logic        out_clk;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];

  baud_tick_gen dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sel        (sel),
    .use_custom (use_custom),
    .div_load   (div_load),
    .div_in     (div_in),
`ifdef BAUD_FRAC_EN
    .div_frac_in(div_frac_in),
`endif
    .os_tick    (os_tick),
    .bit_tick   (bit_tick),
    .out_clk    (out_clk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input int obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0d with no expectation queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  // which: 0 = os_tick, 1 = bit_tick, 2 = out_clk rising. c = -1 on timeout.
  task automatic wait_ev(input int which, input int budget, output int c);
    logic prev;
    bit   done;
    prev = out_clk;
    done = 1'b0;
    c    = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if ((which == 0 && os_tick === 1'b1) ||
          (which == 1 && bit_tick === 1'b1) ||
          (which == 2 && out_clk === 1'b1 && prev === 1'b0)) begin
        c    = cyc;
        done = 1'b1;
      end
      prev = out_clk;
    end
  endtask

  task automatic expect_periods(input string tag, input int period, input int n, inout int t);
    int t1;
    for (int i = 0; i < n; i++) begin
      push(tag, period);
      wait_ev(0, period + 100, t1);
      check(t1 - t);
      t = t1;
    end
  endtask

  initial begin
    int r, t, tt, b0, b1, e;
    bit any_tick, frozen;
    logic held;

    reset      = 1'b1;
    en         = 1'b1;
    sel        = 2'b00;
    use_custom = 1'b0;
    div_load   = 1'b0;
    div_in     = '0;
`ifdef BAUD_FRAC_EN
    div_frac_in = '0;
`endif

    repeat (3) @(negedge clk);
    push("rst_os_tick", 0);  check(int'(os_tick));
    push("rst_bit_tick", 0); check(int'(bit_tick));
    push("rst_out_clk", 0);  check(int'(out_clk));
    push("rst_cnt", 0);      check(int'(dut.cnt));

    reset = 1'b0;
    r = cyc;
    push("first_os_tick", 54);
    wait_ev(0, 200, t);
    check(t - r);
    expect_periods("os_period_115200", 54, 3, t);

    push("out_clk_rise", 432);
    wait_ev(2, 1000, tt);
    check(tt - r);
    push("first_bit_tick", 864);
    wait_ev(1, 1000, tt);
    check(tt - r);
    push("out_clk_fall_at_bit", 0);
    check(int'(out_clk));
    t = tt;

    // Switch to 9600 right after a wrap: the already-loaded 54 period finishes first.
    sel = 2'b11;
    expect_periods("sel9600_old_period", 54, 1, t);
    expect_periods("os_period_9600", 651, 2, t);
    wait_ev(1, 12000, b0);
    push("bit_period_9600", 10416);
    wait_ev(1, 12000, b1);
    check(b1 - b0);
    t = b1;

    repeat (100) @(negedge clk);
    sel = 2'b00;
    expect_periods("mid_switch_keeps_651", 651, 1, t);
    expect_periods("after_switch_54", 54, 1, t);

    repeat (10) @(negedge clk);
    div_in     = 16'd10;
    div_load   = 1'b1;
    use_custom = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    expect_periods("custom_load_keeps_54", 54, 1, t);
    expect_periods("custom_10", 10, 2, t);

    repeat (3) @(negedge clk);
    div_in   = 16'd0;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    expect_periods("clamp_keeps_10", 10, 1, t);
    expect_periods("clamp_2", 2, 2, t);

    // Load lands on the wrap edge itself and must be used by that reload.
    @(negedge clk);
    div_in   = 16'd7;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    push("wrap_load_os_tick", 1); check(int'(os_tick));
    push("wrap_load_period", 2);  check(cyc - t);
    t = cyc;
    expect_periods("wrap_load_7", 7, 2, t);

    repeat (3) @(negedge clk);
    en = 1'b0;
    held = out_clk;
    any_tick = 1'b0;
    frozen = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) any_tick = 1'b1;
      if (out_clk !== held) frozen = 1'b0;
    end
    push("en0_no_ticks", 0);      check(int'(any_tick));
    push("en0_out_clk_frozen", 1); check(int'(frozen));
    push("en0_cnt_held", 3);       check(int'(dut.cnt));
    en = 1'b1;
    e = cyc;
    push("en1_remaining", 4);
    wait_ev(0, 100, t);
    check(t - e);
    expect_periods("en1_period_7", 7, 1, t);

    use_custom = 1'b0;
    wait_ev(2, 2000, tt);
    repeat (30) @(negedge clk);
    push("pre_reset_cnt", 30);    check(int'(dut.cnt));
    push("pre_reset_out_clk", 1); check(int'(out_clk));
    reset    = 1'b1;
    div_in   = 16'd5;
    div_load = 1'b1;
    @(negedge clk);
    push("mid_rst_os_tick", 0);  check(int'(os_tick));
    push("mid_rst_bit_tick", 0); check(int'(bit_tick));
    push("mid_rst_out_clk", 0);  check(int'(out_clk));
    push("mid_rst_cnt", 0);      check(int'(dut.cnt));
    push("mid_rst_custom", 0);   check(int'(dut.custom_div));
    reset    = 1'b0;
    div_load = 1'b0;
    r = cyc;
    push("restart_first_os", 54);
    wait_ev(0, 200, t);
    check(t - r);
    push("restart_out_rise", 432);
    wait_ev(2, 1000, tt);
    check(tt - r);
    push("restart_bit_tick", 864);
    wait_ev(1, 1000, tt);
    check(tt - r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
